wb_uart_tx: RTL

- Wishbone slave UART transmitter with a TX FIFO and a programmable baud divider.
- Sits directly downstream of the OBI-to-Wishbone bridge on the SoC's WB output interface and consumes its WB cycles.
- Lets the CV32E40X core send serial bytes by writing registers.
- Frame format is 8N1, LSB first, line idles high.

---
 rtl/wb_uart_tx_if.sv | 24 ++
 rtl/wb_uart_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx_if.sv
// Wishbone slave bus bundle for wb_uart_tx: the master drives the request side,
// and the UART slave returns the read data and a single-cycle acknowledge.
interface wb_uart_tx_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] wb_addr_i;
  logic [31:0]           wb_wdata_i;
  logic [31:0]           wb_rdata_o;
  logic                  wb_wr_en_i;
  logic [3:0]            wb_byte_en_i;
  logic                  wb_stb_i;
  logic                  wb_cyc_i;
  logic                  wb_ack_o;

  modport master (
    output wb_addr_i, wb_wdata_i, wb_wr_en_i, wb_byte_en_i, wb_stb_i, wb_cyc_i,
    input  wb_rdata_o, wb_ack_o
  );

  modport slave (
    input  wb_addr_i, wb_wdata_i, wb_wr_en_i, wb_byte_en_i, wb_stb_i, wb_cyc_i,
    output wb_rdata_o, wb_ack_o
  );
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone UART transmitter (8N1, LSB first) with TX FIFO and programmable divider.
// Optional level interrupt on "FIFO empty and idle" enabled by macro WB_UART_TX_IRQ_EN.
module wb_uart_tx #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  wb_uart_tx_if.slave wb,
  output logic        ser_tx_o
`ifdef WB_UART_TX_IRQ_EN
  ,
  output logic        irq_o
`endif
);
  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUDRATE);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        r_state, w_state_nxt;
  logic          r_ack;
  logic [31:0]   r_rdata;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_level;
  logic          r_ovf;
  logic [15:0]   r_clkdiv, r_frame_div, r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_irq_en;

  logic          w_req, w_wr, w_rd, w_full, w_empty, w_push, w_push_ok, w_pop;
  logic          w_baud_end, w_tx;
  logic [1:0]    w_addr;
  logic [15:0]   w_div_eff;
  logic [31:0]   w_status, w_rdata_nxt;
  logic          w_unused;

  assign w_req     = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign w_wr      = w_req & wb.wb_wr_en_i;
  assign w_rd      = w_req & ~wb.wb_wr_en_i;
  assign w_addr    = wb.wb_addr_i[3:2];
  assign w_full    = (r_level == (PW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_push    = w_wr & (w_addr == 2'd0) & wb.wb_byte_en_i[0];
  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost.
  assign w_push_ok = w_push & ~w_full;
  assign w_div_eff = (r_clkdiv < 16'd2) ? 16'd2 : r_clkdiv;
  assign w_baud_end = (r_baud == r_frame_div - 16'd1);
  assign w_unused  = ^{wb.wb_addr_i[ADDR_WIDTH-1:4], wb.wb_addr_i[1:0],
                       wb.wb_wdata_i[31:16], wb.wb_byte_en_i[3:2]};

`ifdef WB_UART_TX_IRQ_EN
  logic r_irq;
  assign irq_o = r_irq;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_irq <= 1'b0;
    else         r_irq <= r_irq_en & w_empty & (r_state == IDLE);
  end
`endif

  assign w_status = {16'd0, 8'(r_level), 3'd0, r_irq_en, r_ovf, w_empty, w_full,
                     (r_state != IDLE)};

  always_comb begin
    w_rdata_nxt = 32'd0;
    if (w_rd) begin
      case (w_addr)
        2'd1:    w_rdata_nxt = w_status;
        2'd2:    w_rdata_nxt = {16'd0, r_clkdiv};
        default: w_rdata_nxt = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack    <= 1'b0;
      r_rdata  <= 32'd0;
      r_ovf    <= 1'b0;
      r_clkdiv <= DIV_RST;
      r_irq_en <= 1'b0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= w_rdata_nxt;
      if (w_push & w_full)
        r_ovf <= 1'b1;
      else if (w_wr && w_addr == 2'd1 && wb.wb_byte_en_i[0] && wb.wb_wdata_i[3])
        r_ovf <= 1'b0;
`ifdef WB_UART_TX_IRQ_EN
      if (w_wr && w_addr == 2'd1 && wb.wb_byte_en_i[0])
        r_irq_en <= wb.wb_wdata_i[4];
`endif
      if (w_wr && w_addr == 2'd2) begin
        if (wb.wb_byte_en_i[0]) r_clkdiv[7:0]  <= wb.wb_wdata_i[7:0];
        if (wb.wb_byte_en_i[1]) r_clkdiv[15:8] <= wb.wb_wdata_i[15:8];
      end
    end
  end

  assign wb.wb_ack_o   = r_ack;
  assign wb.wb_rdata_o = r_rdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + {{PW{1'b0}}, w_push_ok} - {{PW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wptr] <= wb.wb_wdata_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = START;
      end
      START: begin
        w_tx = 1'b0;
        if (w_baud_end) w_state_nxt = DATA;
      end
      DATA: begin
        w_tx = r_shift[0];
        if (w_baud_end && r_bit == 3'd7) w_state_nxt = STOP;
      end
      STOP: if (w_baud_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line is decoded from state, so an async reset returns it high immediately.
  assign ser_tx_o = w_tx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_baud <= 16'd0;
      r_bit  <= 3'd0;
    end else if (r_state == IDLE) begin
      r_baud <= 16'd0;
      r_bit  <= 3'd0;
    end else if (w_baud_end) begin
      r_baud <= 16'd0;
      if (r_state == DATA) r_bit <= r_bit + 3'd1;
    end else begin
      r_baud <= r_baud + 16'd1;
    end
  end

  // Divider is captured per frame so CLKDIV writes only affect the next frame.
  always_ff @(posedge clk_i) begin
    if (w_pop) begin
      r_shift     <= r_mem[r_rptr];
      r_frame_div <= w_div_eff;
    end else if (r_state == DATA && w_baud_end) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end
endmodule
